// File: rtl/his_peak_finder_pkg.sv
// Shared sizing defaults and FSM state encoding for the histogram peak finder.
package his_peak_finder_pkg;

  localparam int NB        = 8;        // bin address width
  localparam int BIN_NUM   = 2 ** NB;  // bins per pixel
  localparam int PIXEL_NUM = 200;      // pixels per histogram RAM
  localparam int PIX_W     = 8;        // pixel index width
  localparam int CNT_W     = 10;       // bin count width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_NEXT  = 3'd4
  } state_e;

endpackage

// File: rtl/peak_argmax_acc.sv
// Running-max accumulator: tracks the largest count seen and the index where
// it first appeared. Strictly-greater update keeps ties on the lowest index.
module peak_argmax_acc #(
  parameter int CNT_W = 10,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             first,
  input  logic             vld,
  input  logic [CNT_W-1:0] data,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] max_cnt,
  output logic [IDX_W-1:0] max_bin
);

  logic [CNT_W-1:0] max_cnt_q;
  logic [IDX_W-1:0] max_bin_q;

  // Load on the first sample of a set, then replace only on a strictly larger count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      max_cnt_q <= '0;
      max_bin_q <= '0;
    end else if (clr) begin
      max_cnt_q <= '0;
      max_bin_q <= '0;
    end else if (vld && (first || (data > max_cnt_q))) begin
      max_cnt_q <= data;
      max_bin_q <= idx;
    end
  end

  assign max_cnt = max_cnt_q;
  assign max_bin = max_bin_q;

endmodule

// File: rtl/his_peak_finder.sv
// Scans a completed histogram bank pixel by pixel and streams out the peak
// bin, its count and an above-threshold flag for each pixel.
module his_peak_finder #(
  parameter int NB        = his_peak_finder_pkg::NB,
  parameter int PIXEL_NUM = his_peak_finder_pkg::PIXEL_NUM,
  parameter int PIX_W     = his_peak_finder_pkg::PIX_W,
  parameter int CNT_W     = his_peak_finder_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             acq_done,
  input  logic             his_bank,
  input  logic [CNT_W-1:0] thresh,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [PIX_W-1:0] rd_pixel,
  output logic [NB-1:0]    rd_bin,
  input  logic [CNT_W-1:0] rd_data,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [PIX_W-1:0] peak_pixel,
  output logic [NB-1:0]    peak_bin,
  output logic [CNT_W-1:0] peak_count,
  output logic             peak_hit,
  output logic             busy,
  output logic             overrun
);

  import his_peak_finder_pkg::*;

  localparam logic [NB-1:0]    BIN_LAST = '1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);

  state_e           state_q;
  logic             rd_en_q;
  logic             rd_bank_q;
  logic [PIX_W-1:0] pixel_q;
  logic [NB-1:0]    rd_bin_q;
  logic [CNT_W-1:0] thr_q;
  logic             busy_q;
  logic             overrun_q;
  logic             peak_valid_q;

  // Read-return alignment: data for a read arrives one cycle after the strobe.
  logic             rd_vld_q;
  logic [NB-1:0]    rd_bin_d1_q;

  logic             scan_start;
  logic [CNT_W-1:0] acc_cnt;
  logic [NB-1:0]    acc_bin;

  assign scan_start = (state_q == ST_IDLE) && acq_done;

  // Scan sequencer: issues reads for every bin of every pixel and handshakes results.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      rd_bank_q    <= 1'b0;
      pixel_q      <= '0;
      rd_bin_q     <= '0;
      thr_q        <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      peak_valid_q <= 1'b0;
    end else begin
      // A new acquisition while a scan is running cannot be served; flag it.
      if (acq_done && busy_q) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (acq_done) begin
            rd_bank_q <= his_bank;
            thr_q     <= thresh;
            pixel_q   <= '0;
            rd_bin_q  <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (rd_bin_q == BIN_LAST) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            rd_bin_q <= rd_bin_q + NB'(1);
          end
        end
        ST_DRAIN: begin
          // The last bin is absorbed at this edge, so the peak is final in EMIT.
          peak_valid_q <= 1'b1;
          state_q      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (peak_ready) begin
            peak_valid_q <= 1'b0;
            if (pixel_q == PIX_LAST) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          pixel_q  <= pixel_q + PIX_W'(1);
          rd_bin_q <= '0;
          rd_en_q  <= 1'b1;
          state_q  <= ST_SCAN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Delay the read strobe and bin address to line up with the returning data.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rd_vld_q    <= 1'b0;
      rd_bin_d1_q <= '0;
    end else begin
      rd_vld_q    <= rd_en_q;
      rd_bin_d1_q <= rd_bin_q;
    end
  end

  peak_argmax_acc #(
    .CNT_W (CNT_W),
    .IDX_W (NB)
  ) u_acc (
    .clk     (clk),
    .rst_n   (res),
    .clr     (scan_start),
    .first   (rd_bin_d1_q == '0),
    .vld     (rd_vld_q),
    .data    (rd_data),
    .idx     (rd_bin_d1_q),
    .max_cnt (acc_cnt),
    .max_bin (acc_bin)
  );

  assign rd_en      = rd_en_q;
  assign rd_bank    = rd_bank_q;
  assign rd_pixel   = pixel_q;
  assign rd_bin     = rd_bin_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign peak_valid = peak_valid_q;
  assign peak_pixel = pixel_q;
  assign peak_bin   = acc_bin;
  assign peak_count = acc_cnt;
  // Qualified by valid so the idle/reset value reads as 0 even with a zero threshold.
  assign peak_hit   = peak_valid_q && (acc_cnt >= thr_q);

endmodule

// File: tb/tb_his_peak_finder.sv
// Self-checking bench for his_peak_finder: a histogram RAM model, a scoreboard
// fed from a reference peak search, directed corner cases and random scans.
module tb_his_peak_finder;

  localparam int NB        = 3;
  localparam int BIN_NUM   = 2 ** NB;
  localparam int PIXEL_NUM = 2;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 10;

  typedef struct {
    int pixel;
    int bin;
    int cnt;
    bit hit;
  } exp_t;

  logic             clk = 1'b0;
  logic             res;
  logic             acq_done;
  logic             his_bank;
  logic [CNT_W-1:0] thresh;
  logic             rd_en;
  logic             rd_bank;
  logic [PIX_W-1:0] rd_pixel;
  logic [NB-1:0]    rd_bin;
  logic [CNT_W-1:0] rd_data = '0;
  logic             peak_valid;
  logic             peak_ready;
  logic [PIX_W-1:0] peak_pixel;
  logic [NB-1:0]    peak_bin;
  logic [CNT_W-1:0] peak_count;
  logic             peak_hit;
  logic             busy;
  logic             overrun;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acq_cyc = 0;
  int   results_seen = 0;
  bit   rdy_rand = 1'b0;
  bit   expect_idle = 1'b0;
  exp_t exp_q[$];
  int   hs_q[$];
  exp_t mon_e;

  logic [CNT_W-1:0] mem [2][PIXEL_NUM][BIN_NUM];

  // Captured outputs for the backpressure stability check.
  logic [PIX_W-1:0] cap_pixel;
  logic [NB-1:0]    cap_bin;
  logic [CNT_W-1:0] cap_count;
  logic             cap_hit;
  int               base_results;

  his_peak_finder #(
    .NB        (NB),
    .PIXEL_NUM (PIXEL_NUM),
    .PIX_W     (PIX_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .res        (res),
    .acq_done   (acq_done),
    .his_bank   (his_bank),
    .thresh     (thresh),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_pixel   (rd_pixel),
    .rd_bin     (rd_bin),
    .rd_data    (rd_data),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_pixel (peak_pixel),
    .peak_bin   (peak_bin),
    .peak_count (peak_count),
    .peak_hit   (peak_hit),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Histogram RAM with a one-cycle registered read port.
  always @(posedge clk) begin
    if (rd_en && rd_pixel < PIXEL_NUM) rd_data <= mem[rd_bank][rd_pixel][rd_bin];
  end

  // Random consumer backpressure, active only when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) peak_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the peak is the largest count; among equals the lowest bin wins.
  task automatic push_expect(input int bank, input int thr);
    for (int p = 0; p < PIXEL_NUM; p++) begin
      exp_t e;
      int   mx;
      mx = 0;
      foreach (mem[bank][p][b]) if (int'(mem[bank][p][b]) > mx) mx = int'(mem[bank][p][b]);
      e.bin = -1;
      foreach (mem[bank][p][b]) if (e.bin < 0 && int'(mem[bank][p][b]) == mx) e.bin = b;
      e.pixel = p;
      e.cnt   = mx;
      e.hit   = (mx >= thr);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_row(input int bank, input int pix, input int v[BIN_NUM]);
    for (int b = 0; b < BIN_NUM; b++) mem[bank][pix][b] = CNT_W'(v[b]);
  endtask

  task automatic fill_random(input int bank);
    int mode;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      mode = $urandom_range(0, 3);
      for (int b = 0; b < BIN_NUM; b++) begin
        case (mode)
          0:       mem[bank][p][b] = '0;
          1:       mem[bank][p][b] = CNT_W'($urandom_range(0, 7));
          2:       mem[bank][p][b] = CNT_W'($urandom_range(0, 1023));
          default: mem[bank][p][b] = CNT_W'($urandom_range(0, 3));
        endcase
      end
      if (mode == 3) mem[bank][p][$urandom_range(0, BIN_NUM - 1)] = '1;
    end
  endtask

  // Pulse acq_done from idle, record expectations and check the first read.
  task automatic start_scan(input int bank, input int thr);
    @(posedge clk);
    #1;
    his_bank = bank[0];
    thresh   = CNT_W'(thr);
    acq_done = 1'b1;
    push_expect(bank, thr);
    @(posedge clk);
    #1;
    acq_cyc  = cyc;
    acq_done = 1'b0;
    // Scrambled after the start; the scan must keep the latched values.
    his_bank = $urandom_range(0, 1);
    thresh   = CNT_W'($urandom_range(0, 1023));
    @(negedge clk);
    check("first_rd_en", rd_en, 1);
    check("first_rd_bin", rd_bin, 0);
    check("first_rd_pixel", rd_pixel, 0);
    check("first_rd_bank", rd_bank, bank);
    check("busy_set", busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL idle_timeout: busy=%0d pending=%0d after 1000 cycles", busy, exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_bank"}, rd_bank, 0);
    check({tag, "_rd_pixel"}, rd_pixel, 0);
    check({tag, "_rd_bin"}, rd_bin, 0);
    check({tag, "_peak_valid"}, peak_valid, 0);
    check({tag, "_peak_pixel"}, peak_pixel, 0);
    check({tag, "_peak_bin"}, peak_bin, 0);
    check({tag, "_peak_count"}, peak_count, 0);
    check({tag, "_peak_hit"}, peak_hit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Monitor: compare every accepted result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (expect_idle) begin
        check("busy_drop", busy, 0);
        expect_idle = 1'b0;
      end
      if (res && rd_en) check("rd_pixel_range", rd_pixel < PIXEL_NUM, 1);
      if (res && peak_valid && peak_ready) begin
        hs_q.push_back(cyc);
        results_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: pixel %0d bin %0d with nothing expected", peak_pixel, peak_bin);
        end else begin
          mon_e = exp_q.pop_front();
          check("peak_pixel", peak_pixel, mon_e.pixel);
          check("peak_bin", peak_bin, mon_e.bin);
          check("peak_count", peak_count, mon_e.cnt);
          check("peak_hit", peak_hit, mon_e.hit);
          if (mon_e.pixel == PIXEL_NUM - 1) expect_idle = 1'b1;
        end
      end
    end
  end

  initial begin
    res        = 1'b0;
    acq_done   = 1'b0;
    his_bank   = 1'b0;
    thresh     = '0;
    peak_ready = 1'b0;
    foreach (mem[k, p, b]) mem[k][p][b] = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    res = 1'b1;

    // Basic scan on bank 1 with distinct data in bank 0; also latency checks.
    peak_ready = 1'b1;
    set_row(1, 0, '{0, 3, 9, 2, 0, 0, 0, 1});
    set_row(1, 1, '{5, 0, 0, 0, 0, 0, 0, 7});
    set_row(0, 0, '{1, 1, 1, 1, 1, 1, 1, 900});
    set_row(0, 1, '{800, 1, 1, 1, 1, 1, 1, 1});
    hs_q.delete();
    start_scan(1, 4);
    wait_idle();
    check("hs_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      check("first_result_latency", hs_q[0] - acq_cyc, BIN_NUM + 1);
      check("pixel_period", hs_q[1] - hs_q[0], BIN_NUM + 3);
    end

    // Tie resolves low; max below threshold reports the bin with hit clear.
    set_row(0, 0, '{0, 6, 0, 6, 0, 0, 0, 0});
    set_row(0, 1, '{1, 3, 0, 2, 3, 0, 0, 0});
    start_scan(0, 4);
    wait_idle();

    // All-zero pixel with zero threshold, saturated counts, then threshold 1.
    set_row(0, 0, '{0, 0, 0, 0, 0, 0, 0, 0});
    set_row(0, 1, '{0, 2, 0, 0, 0, 1023, 1023, 0});
    start_scan(0, 0);
    wait_idle();
    start_scan(0, 1);
    wait_idle();

    // Backpressure: hold ready low for 10 cycles in EMIT.
    peak_ready = 1'b0;
    set_row(1, 0, '{4, 2, 8, 8, 1, 0, 3, 5});
    set_row(1, 1, '{0, 0, 0, 2, 0, 0, 9, 0});
    start_scan(1, 5);
    for (int i = 0; i < 100; i++) begin
      if (peak_valid) break;
      @(negedge clk);
    end
    check("bp_valid_seen", peak_valid, 1);
    cap_pixel = peak_pixel;
    cap_bin   = peak_bin;
    cap_count = peak_count;
    cap_hit   = peak_hit;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_hold", peak_valid, 1);
      check("bp_fields_hold", {peak_pixel, peak_bin, peak_count, peak_hit},
            {cap_pixel, cap_bin, cap_count, cap_hit});
      check("bp_no_read", rd_en, 0);
    end
    base_results = results_seen;
    @(posedge clk);
    #1;
    peak_ready = 1'b1;
    @(posedge clk);
    #1;
    peak_ready = 1'b0;
    @(negedge clk);
    check("bp_one_transfer", results_seen - base_results, 1);
    check("bp_valid_dropped", peak_valid, 0);
    @(negedge clk);
    check("bp_next_rd_en", rd_en, 1);
    check("bp_next_pixel", rd_pixel, 1);
    check("bp_next_bin", rd_bin, 0);
    peak_ready = 1'b1;
    wait_idle();

    // Overrun: a second acq_done during pixel 0 is flagged and ignored.
    base_results = results_seen;
    start_scan(0, 2);
    repeat (2) @(posedge clk);
    #1;
    his_bank = 1'b1;
    acq_done = 1'b1;
    @(posedge clk);
    #1;
    acq_done = 1'b0;
    @(negedge clk);
    check("overrun_set", overrun, 1);
    check("overrun_bank_kept", rd_bank, 0);
    wait_idle();
    repeat (20) @(negedge clk);
    check("overrun_no_rescan", busy, 0);
    check("overrun_sticky", overrun, 1);
    check("overrun_two_results", results_seen - base_results, 2);

    // Reset in the middle of a scan, then a clean restart.
    start_scan(1, 3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en && rd_bin == 4) break;
    end
    check("mid_scan_bin", rd_bin, 4);
    res = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    res = 1'b1;
    start_scan(0, 2);
    wait_idle();

    // Random scans with random readiness.
    rdy_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      int bank;
      bank = $urandom_range(0, 1);
      fill_random(0);
      fill_random(1);
      start_scan(bank, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 8) : $urandom_range(0, 1023));
      wait_idle();
    end
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/his_peak_finder.md
Name: his_peak_finder

Overview:
- Downstream consumer of the histogram builder. On each acquisition-complete pulse it scans the just-completed histogram bank (ping-pong, selected by hisNum) pixel by pixel.
- For each pixel it finds the bin with the maximum count and emits {pixel, peak bin, peak count, above-threshold flag} on a valid/ready stream toward the depth/ToF calculation stage.
- Reads the histogram RAM through a registered read port with 1-cycle latency.

Parameters:
- NB, 8, bin address width; BIN_NUM = 2**NB bins per pixel
- PIXEL_NUM, 200, pixels per RAM (matches PIXEL_NUM_PER_RAM)
- PIX_W, 8, pixel index width; must satisfy 2**PIX_W >= PIXEL_NUM
- CNT_W, 10, bin count width (matches peakMax)

Ports:
- clk  in  1  system clock
- res  in  1  reset, asynchronous, active-low
- acq_done  in  1  1-cycle pulse from the builder when an acquisition set finishes
- his_bank  in  1  builder hisNum; the bank that has just completed
- thresh  in  CNT_W  minimum count for a valid peak; sampled at scan start
- rd_en  out  1  histogram read strobe
- rd_bank  out  1  bank being read
- rd_pixel  out  PIX_W  pixel address
- rd_bin  out  NB  bin address
- rd_data  in  CNT_W  bin count; valid exactly 1 cycle after rd_en
- peak_valid  out  1  result valid
- peak_ready  in  1  consumer accepts
- peak_pixel  out  PIX_W  pixel index of the result
- peak_bin  out  NB  index of the maximum bin
- peak_count  out  CNT_W  maximum count
- peak_hit  out  1  1 if peak_count >= thresh
- busy  out  1  scan in progress
- overrun  out  1  sticky: acq_done arrived while busy

Behaviour:
- Reset (res=0, asynchronous): state IDLE. All outputs 0: rd_en, rd_bank, rd_pixel, rd_bin, peak_*, busy, overrun. Max/argmax registers cleared.
- States: IDLE, SCAN, DRAIN, EMIT, NEXT.
- IDLE: on acq_done=1, latch rd_bank<=his_bank and thr_q<=thresh; pixel<=0; go to SCAN; busy<=1.
- SCAN:
  - rd_en=1, rd_bin increments by 1 each cycle from 0 to BIN_NUM-1.
  - After issuing bin BIN_NUM-1, go to DRAIN.
  - Compare pipeline: on the cycle after each read, if rd_data > max_cnt (strictly greater), update max_cnt<=rd_data and max_bin<=bin of that read.
  - The first read of each pixel (bin 0) loads max_cnt/max_bin unconditionally.
  - Ties resolve to the lowest bin index.
- DRAIN: rd_en=0; absorb the final rd_data (bin BIN_NUM-1) into the compare; go to EMIT.
- EMIT:
  - Drive peak_valid=1 with peak_pixel=pixel, peak_bin=max_bin, peak_count=max_cnt, peak_hit=(max_cnt>=thr_q).
  - Outputs hold stable until peak_valid&&peak_ready; peak_valid does not drop without a handshake.
  - On handshake: peak_valid<=0. If pixel==PIXEL_NUM-1, go to IDLE with busy<=0; else go to NEXT.
- NEXT: pixel<=pixel+1, rd_bin<=0; go to SCAN.
- Latency: first read issues 1 cycle after acq_done. With peak_ready held at 1, one pixel takes BIN_NUM+3 cycles (SCAN BIN_NUM, DRAIN 1, EMIT 1, NEXT 1).
- acq_done while busy: ignored. overrun<=1 and stays set until reset. The current scan is unaffected.
- acq_done in the same cycle as the final handshake: treated as arriving while busy, so it sets overrun and does not start a new scan.
- Changes on his_bank and thresh during a scan have no effect (both latched at start).
- All-zero histogram: peak_bin=0, peak_count=0; peak_hit=1 only if thresh==0.
- Count saturation at 2**CNT_W-1 is compared as a normal unsigned value.
- rd_pixel and rd_bin never exceed PIXEL_NUM-1 and BIN_NUM-1.

Decomposition:
- Shared package/header, alongside the existing parameters header: NB, BIN_NUM, PIXEL_NUM, PIX_W, CNT_W, and the state encodings (IDLE=3'd0, SCAN=3'd1, DRAIN=3'd2, EMIT=3'd3, NEXT=3'd4).
- One sub-module, peak_argmax_acc: a running-max accumulator with inputs clr/first, vld, data, idx and outputs max_cnt, max_bin, using the strict-greater rule. Reusable by a later second-peak or crosstalk-rejection stage.

Test Plan (NB=3, PIXEL_NUM=2, CNT_W=10):
- Reset mid-SCAN at bin 4 -> next cycle all outputs 0, state IDLE; a later acq_done starts cleanly at pixel 0, bin 0.
- Bank 1 loaded: pixel 0 = {0,3,9,2,0,0,0,1}, pixel 1 = {5,0,0,0,0,0,0,7}; thresh=4; acq_done with his_bank=1 -> rd_bank=1. Results: (pix 0, bin 2, count 9, hit 1), then (pix 1, bin 7, count 7, hit 1). busy drops after the second handshake.
- Tie: pixel 0 = {0,6,0,6,0,0,0,0} -> peak_bin=1, count 6.
- Threshold: pixel 0 max count 3, thresh=4 -> peak_hit=0, peak_count=3, bin reported.
- Backpressure: peak_ready=0 for 10 cycles in EMIT -> peak_valid stays 1 and fields stay stable, no rd_en. Ready pulse -> exactly one transfer, then pixel 1 scan begins.
- Overrun: second acq_done during pixel 0 SCAN -> overrun=1 sticky; still exactly 2 results; no third scan starts.
